// File: rtl/jt10_adpcm_rom_arb.sv
// jt10_adpcm_rom_arb
// Shares one byte-wide sample memory port between the ADPCM-A and ADPCM-B
// drivers. Each requester gets a one-byte tagged cache that behaves like a ROM.
// Misses are fetched through a level req / one-cycle ack handshake. A has
// priority, and a starve counter forces a B grant after B_STARVE A grants
// while B is waiting.
module jt10_adpcm_rom_arb #(
    parameter int              AW       = 24,
    parameter logic [AW-1:0]   B_BASE   = AW'(24'h100000),
    parameter int              B_STARVE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cen,
    input  logic [19:0]   i_a_addr,
    input  logic [3:0]    i_a_bank,
    input  logic          i_a_roe_n,
    output logic [7:0]    o_a_dout,
    input  logic [AW-1:0] i_b_addr,
    input  logic          i_b_roe_n,
    output logic [7:0]    o_b_dout,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_req,
    input  logic          i_mem_ack,
    input  logic [7:0]    i_mem_data,
    output logic          o_a_late,
    input  logic          i_clr_late
);

    localparam int NREQ = 2;                 // index 0 = ADPCM-A, 1 = ADPCM-B
    localparam int SW   = (B_STARVE < 1) ? 1 : $clog2(B_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(B_STARVE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_mem_req;
    logic            w_mem_req_next;
    logic [AW-1:0]   r_mem_addr;
    logic [AW-1:0]   w_mem_addr_next;
    logic [AW-1:0]   r_req_tag;
    logic [AW-1:0]   w_req_tag_next;
    logic            r_owner;                // 0 = A, 1 = B
    logic            w_owner_next;
    logic            w_grant_a;
    logic            w_grant_b;
    logic            w_done;
    logic            w_starve_full;
    logic [SW-1:0]   r_starve;
    logic            r_a_late;
    logic [AW-1:0]   w_b_mem_addr;

    logic [AW-1:0]   w_tag_in [NREQ];
    logic [7:0]      w_data   [NREQ];
    logic [NREQ-1:0] w_roe_n;
    logic [NREQ-1:0] w_pend;

    // The A tag is the bank/address pair seen as a flat 24-bit byte address.
    assign w_tag_in[0]   = AW'({i_a_bank, i_a_addr});
    assign w_tag_in[1]   = i_b_addr;
    assign w_roe_n       = {i_b_roe_n, i_a_roe_n};
    // B lives in its own region of the shared memory. The sum wraps at 2^AW.
    assign w_b_mem_addr  = i_b_addr + B_BASE;
    assign w_done        = (r_state == ST_REQ) && i_mem_ack;
    assign w_starve_full = (r_starve == STARVE_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cache
            logic          r_valid;
            logic [AW-1:0] r_tag;
            logic [7:0]    r_data;
            logic          w_fill;

            assign w_fill     = w_done && (r_owner == 1'(gi));
            assign w_pend[gi] = !w_roe_n[gi] && (!r_valid || (r_tag != w_tag_in[gi]));
            assign w_data[gi] = r_data;

            // Fill the cache entry on completion. The stored tag is the address
            // that was actually fetched, even if the requester has since moved on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                    r_data  <= '0;
                end else if (w_fill) begin
                    r_valid <= 1'b1;
                    r_tag   <= r_req_tag;
                    r_data  <= i_mem_data;
                end
            end
        end
    endgenerate

    // State and memory-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_req_tag  <= '0;
            r_owner    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_req_tag  <= w_req_tag_next;
            r_owner    <= w_owner_next;
        end
    end

    // Grant selection and handshake sequencing. A wins unless B has already
    // waited through STARVE_MAX consecutive A grants.
    always_comb begin
        w_state_next    = r_state;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_req_tag_next  = r_req_tag;
        w_owner_next    = r_owner;
        w_grant_a       = 1'b0;
        w_grant_b       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend[0] && !(w_pend[1] && w_starve_full)) begin
                    w_grant_a       = 1'b1;
                    w_state_next    = ST_REQ;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = w_tag_in[0];
                    w_req_tag_next  = w_tag_in[0];
                    w_owner_next    = 1'b0;
                end else if (w_pend[1]) begin
                    w_grant_b       = 1'b1;
                    w_state_next    = ST_REQ;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = w_b_mem_addr;
                    w_req_tag_next  = i_b_addr;
                    w_owner_next    = 1'b1;
                end
            end
            ST_REQ: begin
                if (i_mem_ack) begin
                    w_state_next   = ST_IDLE;
                    w_mem_req_next = 1'b0;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    // Count A grants that overtake a waiting B. Any B grant, or B no longer
    // waiting, clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_grant_b || !w_pend[1]) begin
            r_starve <= '0;
        end else if (w_grant_a && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Sticky flag: drvA sampled its data while a fetch for it was still missing.
    // A set in the same cycle as a clear takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_late <= 1'b0;
        end else if (i_cen && w_pend[0]) begin
            r_a_late <= 1'b1;
        end else if (i_clr_late) begin
            r_a_late <= 1'b0;
        end
    end

    assign o_a_dout   = w_data[0];
    assign o_b_dout   = w_data[1];
    assign o_mem_addr = r_mem_addr;
    assign o_mem_req  = r_mem_req;
    assign o_a_late   = r_a_late;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb. Expected memory addresses are queued
// as the stimulus creates misses and popped when the arbiter raises mem_req.
// The memory model returns a byte derived from the expected address.
module tb_jt10_adpcm_rom_arb;

    localparam int AW = 24;
    localparam logic [AW-1:0] BASE = 24'h100000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen = 1'b0;
    logic [19:0]   a_addr = '0;
    logic [3:0]    a_bank = '0;
    logic          a_roe_n = 1'b1;
    logic [7:0]    a_dout;
    logic [AW-1:0] b_addr = '0;
    logic          b_roe_n = 1'b1;
    logic [7:0]    b_dout;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_data = '0;
    logic          a_late;
    logic          clr_late = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_q[$];

    jt10_adpcm_rom_arb #(.AW(AW), .B_BASE(BASE), .B_STARVE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cen      (cen),
        .i_a_addr   (a_addr),
        .i_a_bank   (a_bank),
        .i_a_roe_n  (a_roe_n),
        .o_a_dout   (a_dout),
        .i_b_addr   (b_addr),
        .i_b_roe_n  (b_roe_n),
        .o_b_dout   (b_dout),
        .o_mem_addr (mem_addr),
        .o_mem_req  (mem_req),
        .i_mem_ack  (mem_ack),
        .i_mem_data (mem_data),
        .o_a_late   (a_late),
        .i_clr_late (clr_late)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for mem_req, sampling on falling edges.
    task automatic wait_req(output int waited, output bit ok);
        waited = 0;
        ok = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                waited = i;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'(mem_req), 32'd1);
    endtask

    // Drives a one-cycle acknowledge starting at the current falling edge.
    task automatic pulse_ack(input logic [7:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = '0;
    endtask

    // Serves one request: compare the address with the scoreboard, wait, ack.
    task automatic serve(input int delay, output logic [AW-1:0] addr, output bit ok);
        int w;
        addr = '0;
        wait_req(w, ok);
        if (ok) begin
            if (exp_q.size() == 0) begin
                check("sb_empty", 32'(exp_q.size()), 32'd1);
                ok = 1'b0;
            end else begin
                addr = exp_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(addr));
                repeat (delay) @(negedge clk);
                pulse_ack(mem_byte(addr));
                check("req_drop", 32'(mem_req), 32'd0);
                $display("grant addr=%06h data=%02h", addr, mem_byte(addr));
            end
        end
    endtask

    initial begin
        logic [AW-1:0] addr;
        bit            ok;
        int            w;
        int            cnt;
        bit            is_b;

        // ---- Reset state
        repeat (3) @(negedge clk);
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_b_dout", 32'(b_dout), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_a_late", 32'(a_late), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- 1: single A miss, ack 3 cycles after req
        a_bank = 4'h1; a_addr = 20'h00010; a_roe_n = 1'b0;
        exp_q.push_back(24'h100010);
        serve(2, addr, ok);
        check("t1_a_dout", 32'(a_dout), 32'h5A);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) cnt++;
        end
        check("t1_no_rereq", 32'(cnt), 32'd0);

        // ---- 2: A and B miss together, A first
        a_bank = 4'h2; a_addr = 20'h00030;
        b_addr = 24'h000020; b_roe_n = 1'b0;
        exp_q.push_back(24'h200030);
        exp_q.push_back(24'h100020);
        serve(1, addr, ok);
        check("t2_a_dout", 32'(a_dout), 32'(mem_byte(24'h200030)));
        serve(1, addr, ok);
        check("t2_b_dout", 32'(b_dout), 32'(mem_byte(24'h100020)));

        // ---- 3: B always pending, A moves every grant: A A B A A B A
        a_bank = 4'h3; a_addr = 20'h00100; b_addr = 24'h000040;
        for (int k = 0; k < 7; k++) begin
            is_b = (k % 3) == 2;
            exp_q.push_back(is_b ? (b_addr + BASE) : {a_bank, a_addr});
            serve(1, addr, ok);
            if (is_b) begin
                check("t3_b_dout", 32'(b_dout), 32'(mem_byte(addr)));
                if (k == 2) b_addr = b_addr + 1'b1;
            end else begin
                check("t3_a_dout", 32'(a_dout), 32'(mem_byte(addr)));
                if (k < 6) a_addr = a_addr + 1'b1;
            end
        end
        repeat (3) @(negedge clk);
        check("t3_idle", 32'(mem_req), 32'd0);

        // ---- 4: slow memory, cen pulses during the wait
        check("t4_late_init", 32'(a_late), 32'd0);
        a_bank = 4'h4; a_addr = 20'h00055;
        exp_q.push_back(24'h400055);
        wait_req(w, ok);
        addr = exp_q.pop_front();
        check("t4_mem_addr", 32'(mem_addr), 32'(addr));
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        check("t4_late_set", 32'(a_late), 32'd1);
        repeat (20) @(negedge clk);
        check("t4_late_sticky", 32'(a_late), 32'd1);
        clr_late = 1'b1;
        @(negedge clk);
        clr_late = 1'b0;
        check("t4_late_clr", 32'(a_late), 32'd0);
        cen = 1'b1; clr_late = 1'b1;
        @(negedge clk);
        cen = 1'b0; clr_late = 1'b0;
        check("t4_set_wins", 32'(a_late), 32'd1);
        repeat (375) @(negedge clk);
        check("t4_req_held", 32'(mem_req), 32'd1);
        pulse_ack(mem_byte(addr));
        check("t4_a_dout", 32'(a_dout), 32'(mem_byte(24'h400055)));
        clr_late = 1'b1;
        @(negedge clk);
        clr_late = 1'b0;
        check("t4_late_final", 32'(a_late), 32'd0);

        // ---- 5: A address changes while its fetch is in flight
        a_bank = 4'h0; a_addr = 20'h00010;
        exp_q.push_back(24'h000010);
        wait_req(w, ok);
        addr = exp_q.pop_front();
        check("t5_mem_addr0", 32'(mem_addr), 32'(addr));
        a_addr = 20'h00011;
        exp_q.push_back(24'h000011);
        @(negedge clk);
        pulse_ack(mem_byte(addr));
        check("t5_a_dout0", 32'(a_dout), 32'(mem_byte(24'h000010)));
        wait_req(w, ok);
        check("t5_next_idle", 32'(w), 32'd1);
        addr = exp_q.pop_front();
        check("t5_mem_addr1", 32'(mem_addr), 32'(addr));
        pulse_ack(mem_byte(addr));
        check("t5_a_dout1", 32'(a_dout), 32'(mem_byte(24'h000011)));

        // ---- 6: reset in the middle of a fetch, stale ack afterwards
        a_addr = 20'h00012;
        wait_req(w, ok);
        check("t6_mem_addr", 32'(mem_addr), 32'h000012);
        rst_n = 1'b0;
        a_roe_n = 1'b1; b_roe_n = 1'b1;
        #1;
        check("t6_req_async", 32'(mem_req), 32'd0);
        check("t6_a_dout", 32'(a_dout), 32'd0);
        check("t6_b_dout", 32'(b_dout), 32'd0);
        check("t6_mem_addr0", 32'(mem_addr), 32'd0);
        @(negedge clk);
        pulse_ack(8'hEE);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_ack(8'hEE);
        check("t6_ack_ign_a", 32'(a_dout), 32'd0);
        check("t6_ack_ign_b", 32'(b_dout), 32'd0);
        check("t6_ack_ign_req", 32'(mem_req), 32'd0);
        // Previously cached addresses must miss again.
        a_addr = 20'h00011; a_roe_n = 1'b0; b_roe_n = 1'b0;
        exp_q.push_back(24'h000011);
        exp_q.push_back(b_addr + BASE);
        serve(1, addr, ok);
        check("t6_a_refetch", 32'(a_dout), 32'(mem_byte(24'h000011)));
        serve(1, addr, ok);
        check("t6_b_refetch", 32'(b_dout), 32'(mem_byte(addr)));
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt10_adpcm_rom_arb.md
Name: jt10_adpcm_rom_arb

Overview:
- Shares one external byte-wide sample ROM/SDRAM port between the ADPCM-A driver (6-channel, time-multiplexed) and the ADPCM-B driver.
- Each requester sees a ROM-like interface: address plus active-low output enable, with data held steady.
- The arbiter keeps a one-byte tagged cache per requester, fetches misses through a req/ack memory handshake, gives ADPCM-A priority, and stops ADPCM-B from starving.
- Sits between jt10_adpcm_drvA / ADPCM-B driver and the top-level memory controller.

Parameters:
- AW, 24, memory address width.
- B_BASE, 24'h100000, byte offset added to ADPCM-B addresses on the memory port.
- B_STARVE, 2, maximum consecutive A grants while B is pending before B is forced.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cen  in  1  ADPCM-A slot enable (666 kHz); the cycle on which drvA samples a_dout
- a_addr  in  20  ADPCM-A byte address
- a_bank  in  4  ADPCM-A bank
- a_roe_n  in  1  ADPCM-A read enable, active low
- a_dout  out  8  ADPCM-A data
- b_addr  in  AW  ADPCM-B byte address
- b_roe_n  in  1  ADPCM-B read enable, active low
- b_dout  out  8  ADPCM-B data
- mem_addr  out  AW  memory byte address
- mem_req  out  1  memory request, level
- mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle
- mem_data  in  8  memory read data
- a_late  out  1  sticky: drvA sampled while its fetch was outstanding
- clr_late  in  1  clears a_late

Behaviour:
- Reset:
  - a_dout, b_dout = 0; mem_req = 0; mem_addr = 0; a_late = 0.
  - Cache valid bits = 0; starve counter = 0; FSM = IDLE.
  - A reset asserted mid-transaction drops mem_req immediately and abandons the fetch. A mem_ack arriving after reset is ignored.
- Tags:
  - A tag is {a_bank, a_addr}, 24 bits, zero-extended/truncated to AW.
  - B tag is b_addr.
  - A miss (a_pend) = !a_roe_n && (!a_valid || a_tag != {a_bank, a_addr}), computed combinationally. b_pend is formed the same way.
  - With roe_n high there is no request; cache contents and outputs are retained.
- FSM states: IDLE, REQ.
  - IDLE:
    - If a_pend && !(b_pend && starve == B_STARVE): grant A. Latch mem_addr = {a_bank, a_addr}, mem_req <= 1, owner = A, go to REQ.
    - Else if b_pend: grant B. mem_addr = b_addr + B_BASE (modulo 2^AW), mem_req <= 1, owner = B, go to REQ.
    - Else stay in IDLE.
  - REQ:
    - mem_addr and owner stay stable.
    - On mem_ack: owner cache data <= mem_data, tag <= latched request address, valid <= 1; mem_req <= 0; go to IDLE.
  - The next grant is evaluated in the cycle after ack, so there is at least one IDLE cycle between requests.
  - Latency: mem_req rises on the first clk edge after the miss is visible. The owner's dout updates on the edge that samples mem_ack.
- Starve counter:
  - Increments on each A grant while b_pend; saturates at B_STARVE.
  - Resets to 0 on a B grant or when !b_pend.
- Address change while in flight: the completion still writes the old tag/data. The new address then misses in the next IDLE cycle and is fetched normally. There is no abort on the memory side.
- Simultaneous first misses on A and B with starve = 0: A first, then B.
- a_late:
  - Set on any clk edge with cen && a_pend.
  - clr_late clears it. If set and clear coincide, set wins.
- Widths: B_BASE addition wraps silently. All outputs are registered.

Test Plan:
1. Reset, then a_roe_n = 0, bank = 1, addr = 0x00010; memory acks 3 cycles after req with 0x5A -> mem_req = 1 with mem_addr = 0x100010; a_dout = 0x5A after ack; mem_req low the next cycle; no second request while the address is unchanged.
2. A and B miss in the same cycle (b_addr = 0x20) -> A is serviced first, then B with mem_addr = 0x100020; b_dout = mem_data of the second ack.
3. B pending continuously, A changes address every grant, B_STARVE = 2 -> grant order A, A, B, A, A, B…; B is never delayed beyond 2 A grants.
4. Memory ack delayed 400 cycles, cen pulses during the wait -> a_late = 1 and stays set; clr_late clears it; a simultaneous cen && a_pend with clr_late leaves it at 1.
5. A address changes from 0x10 to 0x11 during REQ -> ack stores tag 0x10; a new request for 0x11 follows in the next IDLE cycle; a_dout shows data for 0x10, then 0x11.
6. rst_n asserted while mem_req = 1, then mem_ack pulses -> all outputs 0, caches invalid; the post-reset ack is ignored and no cache update occurs.
